// File: rtl/bayer_demosaic_if.sv
// Raw Bayer video in, demosaiced RGB video out; both sides share one sync convention.
interface bayer_demosaic_if;
    logic       in_vsync;
    logic       in_hsync;
    logic       in_den;
    logic [7:0] in_raw;
    logic       out_vsync;
    logic       out_hsync;
    logic       out_den;
    logic [7:0] out_data_R;
    logic [7:0] out_data_G;
    logic [7:0] out_data_B;

    modport master (
        output in_vsync, in_hsync, in_den, in_raw,
        input  out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B
    );
    modport slave (
        input  in_vsync, in_hsync, in_den, in_raw,
        output out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B
    );
endinterface

// File: rtl/bayer_demosaic.sv
// 3x3 bilinear Bayer-to-RGB demosaic with two line buffers.
// Stages: window capture, neighbour sums, site select; syncs ride alongside.
module bayer_demosaic #(
    parameter int source_h  = 512,
    parameter int source_v  = 512,
    parameter int BAYER_PAT = 0
) (
    input logic             clk,
    input logic             reset_n,
    bayer_demosaic_if.slave bus
);
    localparam int XW    = $clog2(source_h);
    localparam int YW    = $clog2(source_v);
    localparam bit PAT_X = (BAYER_PAT % 2) == 1;
    localparam bit PAT_Y = ((BAYER_PAT / 2) % 2) == 1;

    typedef logic [2:0][7:0] row_t;

    // Column -1 mirrors onto column +1 at the left edge.
    function automatic row_t reflect_w(input row_t r, input logic x_one);
        return {r[2], r[1], x_one ? r[2] : r[0]};
    endfunction

    logic [XW-1:0]        x_cnt, x_cur, x_s1;
    logic [YW-1:0]        y_cnt, y_s1;
    logic                 hs_d;
    logic [7:0]           lb1 [source_h];
    logic [7:0]           lb2 [source_h];
    logic [7:0]           lb1_rd, lb2_rd;
    logic [2:0][2:0][7:0] win;        // [row y-2,y-1,y][col x-2,x-1,x]
    logic [2:0][2:0]      sync_pipe;  // {vsync,hsync,den} per stage

    assign x_cur  = (bus.in_hsync && !hs_d) ? '0 : x_cnt;
    assign lb1_rd = lb1[x_cur];
    assign lb2_rd = lb2[x_cur];

    always_ff @(posedge clk) begin
        if (reset_n && bus.in_den) begin
            lb1[x_cur] <= bus.in_raw;
            lb2[x_cur] <= lb1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
            x_s1  <= '0;
            y_s1  <= '0;
            win   <= '0;
        end else begin
            hs_d  <= bus.in_hsync;
            x_cnt <= x_cur + XW'(bus.in_den);
            if (!bus.in_vsync)
                y_cnt <= '0;
            else if (hs_d && !bus.in_hsync)
                y_cnt <= y_cnt + YW'(1);
            if (bus.in_den) begin
                x_s1   <= x_cur;
                y_s1   <= y_cnt;
                win[0] <= {lb2_rd, win[0][2:1]};
                win[1] <= {lb1_rd, win[1][2:1]};
                win[2] <= {bus.in_raw, win[2][2:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[1:0], {bus.in_vsync, bus.in_hsync, bus.in_den}};
    end

    // Row -1 mirrors onto row +1 (the current raw row) at the top edge.
    logic       x_one, y_one, border;
    row_t       top, mid, bot;
    logic [9:0] sum_o, sum_d;
    logic [8:0] sum_we, sum_ns;
    logic [1:0] site;

    assign x_one  = (x_s1 == XW'(1));
    assign y_one  = (y_s1 == YW'(1));
    assign border = (x_s1 == '0) || (y_s1 == '0);
    assign top    = reflect_w(y_one ? win[2] : win[0], x_one);
    assign mid    = reflect_w(win[1], x_one);
    assign bot    = reflect_w(win[2], x_one);
    assign sum_o  = 10'(top[1]) + 10'(bot[1]) + 10'(mid[0]) + 10'(mid[2]);
    assign sum_d  = 10'(top[0]) + 10'(top[2]) + 10'(bot[0]) + 10'(bot[2]);
    assign sum_we = 9'(mid[0]) + 9'(mid[2]);
    assign sum_ns = 9'(top[1]) + 9'(bot[1]);
    // Centre sits at (x-1, y-1), so its parity is the inverse of the pixel's.
    assign site   = {~y_s1[0] ^ PAT_Y, ~x_s1[0] ^ PAT_X};

    logic            border_s2;
    logic [1:0]      site_s2;
    logic [7:0]      c_s2;
    logic [9:0]      so_s2, sd_s2;
    logic [8:0]      we_s2, ns_s2;
    logic [2:0][7:0] rgb_n, rgb_q;   // [2]=R [1]=G [0]=B

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            border_s2 <= 1'b0;
            site_s2   <= '0;
            c_s2      <= '0;
            so_s2     <= '0;
            sd_s2     <= '0;
            we_s2     <= '0;
            ns_s2     <= '0;
        end else begin
            border_s2 <= border;
            site_s2   <= site;
            c_s2      <= mid[1];
            so_s2     <= sum_o;
            sd_s2     <= sum_d;
            we_s2     <= sum_we;
            ns_s2     <= sum_ns;
        end
    end

    always_comb begin
        rgb_n = '0;
        case (site_s2)
            2'b00:   rgb_n = {c_s2, so_s2[9:2], sd_s2[9:2]};
            2'b01:   rgb_n = {we_s2[8:1], c_s2, ns_s2[8:1]};
            2'b10:   rgb_n = {ns_s2[8:1], c_s2, we_s2[8:1]};
            default: rgb_n = {sd_s2[9:2], so_s2[9:2], c_s2};
        endcase
        if (border_s2) rgb_n = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= rgb_n;
    end

    assign bus.out_vsync  = sync_pipe[2][2];
    assign bus.out_hsync  = sync_pipe[2][1];
    assign bus.out_den    = sync_pipe[2][0];
    assign bus.out_data_R = rgb_q[2];
    assign bus.out_data_G = rgb_q[1];
    assign bus.out_data_B = rgb_q[0];
endmodule

// File: tb/tb_bayer_demosaic.sv
// Scoreboarded bench: RGGB and BGGR instances driven in lockstep, checked
// every cycle against a coordinate-based interpolation model.
module tb_bayer_demosaic;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bayer_demosaic_if bus0 ();
    bayer_demosaic_if bus3 ();

    bayer_demosaic #(.source_h(16), .source_v(16), .BAYER_PAT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    bayer_demosaic #(.source_h(16), .source_v(16), .BAYER_PAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3));

    typedef struct packed {
        logic [2:0]  sync;
        logic        chk;
        logic [23:0] rgb0;
        logic [23:0] rgb3;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] img [2][16][16];
    int         n_asrt = 0;
    int         n_fail = 0;

    function automatic int px(input int d, input int x, input int y);
        return int'(img[d][y < 0 ? -y : y][x < 0 ? -x : x]);
    endfunction

    function automatic logic [23:0] model(input int d, input int x, input int y, input int pat);
        int cx, cy, c, we, ns, dg, sx, sy, r, g, b;
        if (x == 0 || y == 0) return '0;
        cx = x - 1;
        cy = y - 1;
        c  = px(d, cx, cy);
        we = px(d, cx - 1, cy) + px(d, cx + 1, cy);
        ns = px(d, cx, cy - 1) + px(d, cx, cy + 1);
        dg = px(d, cx - 1, cy - 1) + px(d, cx + 1, cy - 1) + px(d, cx - 1, cy + 1) + px(d, cx + 1, cy + 1);
        sx = (cx + pat % 2) % 2;
        sy = (cy + pat / 2) % 2;
        if (sx == 0 && sy == 0) begin r = c; g = (we + ns) / 4; b = dg / 4; end
        else if (sy == 0)       begin g = c; r = we / 2; b = ns / 2; end
        else if (sx == 0)       begin g = c; b = we / 2; r = ns / 2; end
        else                    begin b = c; g = (we + ns) / 4; r = dg / 4; end
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // mode 0 flat, 1 colour planes, 2 truncation corners, other random
    function automatic logic [7:0] scene(input int mode, input int x, input int y, input int pat);
        int sx, sy;
        sx = (x + pat % 2) % 2;
        sy = (y + pat / 2) % 2;
        case (mode)
            0: return 8'd100;
            1: return (sx == 0 && sy == 0) ? 8'd200 : (sx == 1 && sy == 1) ? 8'd40 : 8'd100;
            2: begin
                if ((x == 2 && y == 1) || (x == 2 && y == 3) || (x == 1 && y == 2)) return 8'd1;
                if (x == 3 && y == 2) return 8'd2;
                if (x == 2 && y == 0) return 8'd255;
                if (x == 4 && y == 0) return 8'd254;
                return 8'd0;
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic rn, input logic vs, input logic hs, input logic den,
                       input logic [7:0] r0, input logic [7:0] r3,
                       input logic [23:0] e0, input logic [23:0] e3);
        exp_t o, n;
        @(negedge clk);
        if (sb.size() == 3) begin
            o = sb.pop_front();
            check("sync0", 24'({bus0.out_vsync, bus0.out_hsync, bus0.out_den}), 24'(o.sync));
            check("sync3", 24'({bus3.out_vsync, bus3.out_hsync, bus3.out_den}), 24'(o.sync));
            if (o.chk) begin
                check("rgb0", {bus0.out_data_R, bus0.out_data_G, bus0.out_data_B}, o.rgb0);
                check("rgb3", {bus3.out_data_R, bus3.out_data_G, bus3.out_data_B}, o.rgb3);
            end
        end
        reset_n       = rn;
        bus0.in_vsync = vs; bus0.in_hsync = hs; bus0.in_den = den; bus0.in_raw = r0;
        bus3.in_vsync = vs; bus3.in_hsync = hs; bus3.in_den = den; bus3.in_raw = r3;
        n = '0;
        if (!rn) begin
            // everything in flight is flushed to zero by the reset edge
            n.chk = 1'b1;
            foreach (sb[i]) sb[i] = n;
        end else begin
            n.sync = {vs, hs, den};
            n.chk  = den;
            n.rgb0 = e0;
            n.rgb3 = e3;
        end
        sb.push_back(n);
    endtask

    task automatic frame(input int mode, input int w, input int h, input int gap_x,
                         input int only_x, input int rst_x, input int rst_y);
        int xp;
        logic den;
        logic [23:0] e0, e3;
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0);
            xp = 0;
            for (int k = 0; k < w; k++) begin
                if (k == gap_x) repeat (3) cyc(1, 1, 1, 0, 0, 0, 0, 0);
                if (y == rst_y && k == rst_x) begin
                    cyc(0, 1, 1, 1, 8'd100, 8'd100, 0, 0);
                    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
                    return;
                end
                den = (only_x < 0) || (y == 1 && k == only_x);
                if (den) begin
                    img[0][y][xp] = scene(mode, xp, y, 0);
                    img[1][y][xp] = scene(mode, xp, y, 3);
                    e0 = model(0, xp, y, 0);
                    e3 = model(1, xp, y, 3);
                    cyc(1, 1, 1, 1, img[0][y][xp], img[1][y][xp], e0, e3);
                    xp++;
                end else begin
                    cyc(1, 1, 1, 0, 0, 0, 0, 0);
                end
            end
        end
        // first vblank cycle also drops hsync: vsync clear must win over y++
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus0.in_vsync = 1'b0; bus0.in_hsync = 1'b0; bus0.in_den = 1'b0; bus0.in_raw = '0;
        bus3.in_vsync = 1'b0; bus3.in_hsync = 1'b0; bus3.in_den = 1'b0; bus3.in_raw = '0;
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, 8, 4, -1, 3, -1, -1);   // single den pulse, sync latency
        frame(0, 6, 4, -1, -1, -1, -1);  // flat field
        frame(1, 6, 5, -1, -1, -1, -1);  // colour planes, RGGB vs BGGR
        frame(2, 6, 4, -1, -1, -1, -1);  // truncation corners
        frame(0, 8, 4, 4, -1, -1, -1);   // flat with den gap
        frame(3, 8, 4, 4, -1, -1, -1);   // random with den gap
        frame(0, 8, 4, -1, -1, 3, 2);    // reset mid-frame
        frame(0, 6, 4, -1, -1, -1, -1);  // flat after reset
        frame(3, 8, 6, -1, -1, -1, -1);  // random
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Converts the 8-bit raw Bayer stream from the sensor front end into 8-bit RGB using 3×3 bilinear interpolation. It sits directly upstream of the AWB stage and drives that stage's vsync/hsync/den/R/G/B inputs with the same sync convention. Two internal line buffers hold the previous two raw rows; sync signals pass through with a fixed 2-cycle latency.

## Interface
- source_h, 512, active pixels per line; sets line-buffer depth
- source_v, 512, active lines per frame; sizes the row counter
- BAYER_PAT, 0, colour at raw (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
- clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_vsync  in  1  high during active frame; low = vertical blanking
- in_hsync  in  1  high during active line
- in_den  in  1  raw pixel valid; only asserted while in_hsync high
- in_raw  in  8  raw Bayer sample
- out_vsync, out_hsync, out_den  out  1 each  inputs delayed exactly 2 cycles
- out_data_R, out_data_G, out_data_B  out  8 each  interpolated RGB

## Operation
- Column counter x: cleared on the in_hsync rising edge; increments after each in_den pixel. Row counter y: cleared while in_vsync is low; increments on the in_hsync falling edge.
- Line buffers LB1 (row y-1) and LB2 (row y-2), each source_h×8, addressed by x. On in_den, read old contents at x, then write in_raw to LB1[x] and LB1's old value to LB2[x].
- The 3×3 window is formed from three 3-deep column shift registers (rows y-2, y-1, y). The window advances only on in_den; it holds while in_den is low.
- Output pixel (x,y) is demosaiced at raw centre (x-1, y-1):
  - Index -1 is reflected to +1, so N=S when y=1 and W=E when x=1.
  - Bayer parity of the centre comes from (x-1, y-1) and BAYER_PAT.
- Output row 0 and output column 0 are forced to R=G=B=0. out_den still follows in_den for those pixels.
- Interpolation (c = centre; N/S/E/W = orthogonal neighbours; D = four diagonals):
  - R site: R=c, G=(N+S+E+W)>>2, B=ΣD>>2
  - B site: B=c, G=(N+S+E+W)>>2, R=ΣD>>2
  - G site on an R row: G=c, R=(W+E)>>1, B=(N+S)>>1
  - G site on a B row: G=c, B=(W+E)>>1, R=(N+S)>>1
- Arithmetic: sums are 10 bits wide, shifts truncate (no rounding), and results always fit in 8 bits, so no saturation is needed.
- The last raw row and last raw column are never used as centres.
- Line-buffer contents are not reset. Stale data is never used because row 0 is forced to 0 and row 1 uses only the current row and LB1.

## Timing
- Latency: input sampled at edge k → all outputs valid after edge k+2, for both pixel data and syncs.
- Throughput: one pixel per clock. No back-pressure; downstream must accept every den cycle.
- in_den low mid-line: x and the window freeze. The corresponding output cycle has out_den=0 and RGB data unspecified.
- in_vsync low at any point: y is cleared. The next frame starts a fresh row 0, even if the previous frame was truncated.
- Simultaneous in_hsync falling edge and in_vsync low: the vsync clear takes priority, so y=0.
- reset_n low at an edge: all outputs are 0 after that edge, and x, y and the pipeline registers are 0.
  - Outputs stay 0 for 2 cycles after reset_n returns high.
  - Processing restarts at the next in_hsync rising edge, treated as row 0 only after in_vsync has been low.

## Test plan
- Latency and syncs: 8×4 frame with a single in_den pulse → out_den pulse exactly 2 cycles later; out_vsync and out_hsync track their inputs with 2 cycles of delay.
- Flat field: every raw = 100, BAYER_PAT=0 → all interior outputs (x≥1, y≥1) are R=G=B=100; row 0 and column 0 are 0,0,0.
- Colour planes: RGGB mosaic with R sites = 200, G = 100, B = 40 → every interior output is (200,100,40) at all four site types, including x=1 and y=1, where reflection applies.
- Pattern parameter: same scene resampled as BGGR with BAYER_PAT=3 → identical interior RGB output (200,100,40).
- Truncation: R site with N,S,E,W = 1,1,1,2 → G = 5>>2 = 1. G site on an R row with W=255, E=254 → R = 254.
- Gaps and reset: in_den dropped for 3 cycles mid-line → output values unchanged versus the gapless run, shifted by 3 cycles.
  - reset_n low for 1 cycle mid-frame → all outputs 0 on the next edge.
  - After the next vsync low, the flat-field result is reproduced.
